// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Default limits assume a 25 MHz system clock.
package debounce_pkg;

  localparam int DEFAULT_COUNT_LIMIT = 250000;    // 10 ms
  localparam int DEFAULT_LONG_LIMIT  = 25000000;  // 1 s

  // Ceiling log2, usable in constant expressions on tools without $clog2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stability counter, registered
// rise/fall pulses and an optional long-press hold counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   COUNT_LIMIT = DEFAULT_COUNT_LIMIT,
  parameter int   LONG_LIMIT  = DEFAULT_LONG_LIMIT,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_din,
  output logic o_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);

  localparam int CW = (clog2(COUNT_LIMIT + 1) > 0) ? clog2(COUNT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(COUNT_LIMIT);

  logic          r_sync_p0;
  logic          r_sync_p1;
  logic [CW-1:0] r_cnt;
  logic          r_data;
  logic          r_rise;
  logic          r_fall;
  logic          w_s;

  assign w_s = r_sync_p1;

  // Stage p0 -> p1: metastability guard for the asynchronous switch input
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_sync_p0 <= INIT_LEVEL;
      r_sync_p1 <= INIT_LEVEL;
    end else begin
      r_sync_p0 <= i_din;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Level only updates once s has disagreed for COUNT_LIMIT consecutive edges;
  // if s has fallen back by the deciding edge, the level is simply re-loaded.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cnt  <= '0;
      r_data <= INIT_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if ((w_s != r_data) && (r_cnt < CNT_MAX)) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (r_cnt == CNT_MAX) begin
        r_cnt  <= '0;
        r_data <= w_s;
        r_rise <= w_s & ~r_data;
        r_fall <= ~w_s & r_data;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_data = r_data;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

  generate
    if (LONG_LIMIT > 0) begin : g_long
      localparam int HW = clog2(LONG_LIMIT + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_LIMIT);

      logic [HW-1:0] r_hcnt;
      logic          r_long;

      // Hold counter saturates at HOLD_MAX so a held button pulses only once
      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          r_hcnt <= '0;
          r_long <= 1'b0;
        end else if (r_data) begin
          if (r_hcnt < HOLD_MAX) begin
            r_hcnt <= r_hcnt + HW'(1);
            r_long <= (r_hcnt == (HOLD_MAX - HW'(1)));
          end else begin
            r_long <= 1'b0;
          end
        end else begin
          r_hcnt <= '0;
          r_long <= 1'b0;
        end
      end

      assign o_long = r_long;
    end else begin : g_no_long
      assign o_long = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: NUM_CH independent debounce_channel instances
// sharing one clock and asynchronous active-low reset.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   NUM_CH      = 4,
  parameter int   COUNT_LIMIT = DEFAULT_COUNT_LIMIT,
  parameter int   LONG_LIMIT  = DEFAULT_LONG_LIMIT,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_data,
  output logic [NUM_CH-1:0] o_data,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_long
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .COUNT_LIMIT (COUNT_LIMIT),
      .LONG_LIMIT  (LONG_LIMIT),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_ch (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_din   (i_data[g]),
      .o_data  (o_data[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g]),
      .o_long  (o_long[g])
    );
  end

endmodule
